// File: rtl/gbsha_fir_pkg.sv
// Shared widths, slot pin map and coefficient rule for the gbsha FIR slot design.
package gbsha_fir_pkg;

  localparam int N_TAPS_DEF     = 2;
  localparam int BW_IN_DEF      = 2;
  localparam int BW_OUT_DEF     = 8;
  localparam int BW_PRODUCT_DEF = 8;
  localparam int BW_SUM_DEF     = 8;

  localparam int CLK_BIT = 0;
  localparam int RST_BIT = 1;
  localparam int X_LSB   = 2;

  // Tap k carries the fixed weight k+1.
  function automatic logic [31:0] coef(input int k);
    return 32'(k + 1);
  endfunction

endpackage

// File: rtl/gbsha_fir_if.sv
// 8-in/8-out user slot pin bundle; the user side reads io_in and drives io_out.
interface gbsha_fir_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport slot (output io_in, input io_out);
  modport user (input io_in, output io_out);
endinterface

// File: rtl/gbsha_fir_core.sv
// Direct-form FIR: delay line, constant-coefficient products and a wrapping sum.
module gbsha_fir_core
  import gbsha_fir_pkg::*;
#(
  parameter int N_TAPS     = N_TAPS_DEF,
  parameter int BW_in      = BW_IN_DEF,
  parameter int BW_out     = BW_OUT_DEF,
  parameter int BW_product = BW_PRODUCT_DEF,
  parameter int BW_sum     = BW_SUM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BW_in-1:0]  x_in,
  output logic [BW_out-1:0] y
);

  logic [BW_in-1:0]  d_q [N_TAPS];
  logic [BW_in-1:0]  d_d [N_TAPS];
  logic [BW_out-1:0] y_q;
  logic [BW_out-1:0] y_d;
  logic [BW_sum-1:0] sum_s;
  logic [31:0]       prod_full_s;

  // Each product wraps at BW_product bits before it enters the BW_sum-bit sum.
  always_comb begin
    sum_s       = '0;
    prod_full_s = 32'd0;
    for (int k = 0; k < N_TAPS; k++) begin
      prod_full_s = coef(k) * 32'(d_q[k]);
      sum_s       = sum_s + BW_sum'(BW_product'(prod_full_s));
    end
  end

  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      if (k == 0) begin
        d_d[k] = x_in;
      end else begin
        d_d[k] = d_q[k-1];
      end
    end
    // Widen first so the output is truncated or zero-extended as widths require.
    y_d = BW_out'(32'(sum_s));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        d_q[k] <= '0;
      end
      y_q <= '0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) begin
        d_q[k] <= d_d[k];
      end
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/gbsha_fir_top.sv
// Slot wrapper: maps clk/rst/x_in from io_in and zero-pads the filter output onto io_out.
module gbsha_fir_top
  import gbsha_fir_pkg::*;
#(
  parameter int N_TAPS     = N_TAPS_DEF,
  parameter int BW_in      = BW_IN_DEF,
  parameter int BW_out     = BW_OUT_DEF,
  parameter int BW_product = BW_PRODUCT_DEF,
  parameter int BW_sum     = BW_SUM_DEF
) (
  gbsha_fir_if.user io
);

  logic [BW_out-1:0] y_s;
  logic [7:0]        out_s;
  logic [7:0]        unused_pins_s;

  // Pins above x_in carry no meaning; they are tapped here only to keep them named.
  assign unused_pins_s = io.io_in;

  gbsha_fir_core #(
    .N_TAPS     (N_TAPS),
    .BW_in      (BW_in),
    .BW_out     (BW_out),
    .BW_product (BW_product),
    .BW_sum     (BW_sum)
  ) u_core (
    .clk  (io.io_in[CLK_BIT]),
    .rst  (io.io_in[RST_BIT]),
    .x_in (io.io_in[X_LSB +: BW_in]),
    .y    (y_s)
  );

  always_comb begin
    out_s              = 8'd0;
    out_s[BW_out-1:0]  = y_s;
  end

  assign io.io_out = out_s;

endmodule

// File: tb/tb_gbsha_fir_top.sv
// Directed bench: default filter, 8-tap wrap configuration and a 6-bit-output pin isolation copy.
module tb_gbsha_fir_top;

  logic       clk;
  logic       rst_s;
  logic [1:0] x_s;
  logic [3:0] hi_c;
  logic       rst_w;
  logic [5:0] x_w;
  int         total;
  int         bad;

  gbsha_fir_if if_a ();
  gbsha_fir_if if_b ();
  gbsha_fir_if if_c ();

  assign if_a.io_in = {4'b0000, x_s, rst_s, clk};
  assign if_c.io_in = {hi_c, x_s, rst_s, clk};
  assign if_b.io_in = {x_w, rst_w, clk};

  gbsha_fir_top u_dut_a (.io(if_a));

  gbsha_fir_top #(
    .N_TAPS(8), .BW_in(6), .BW_out(8), .BW_product(8), .BW_sum(8)
  ) u_dut_b (.io(if_b));

  gbsha_fir_top #(
    .N_TAPS(2), .BW_in(2), .BW_out(6), .BW_product(8), .BW_sum(8)
  ) u_dut_c (.io(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle and scramble the ignored pins of copy c.
  task automatic tick();
    @(posedge clk);
    #1;
    hi_c = 4'($urandom_range(15, 0));
  endtask

  // Check the default copy and the pin-isolation copy against the same value.
  task automatic chk_ac(input string tag, input logic [7:0] exp);
    chk({tag, "_a"}, if_a.io_out, exp);
    chk({tag, "_c"}, if_c.io_out, exp);
  endtask

  logic [7:0] step_exp [4];
  logic [7:0] rstm_exp [3];
  logic [7:0] flush_exp [3];
  logic [7:0] imp_exp [4];
  logic [7:0] wrap_exp [10];

  initial begin
    total = 0;
    bad   = 0;
    step_exp  = '{8'd0, 8'd3, 8'd9, 8'd9};
    rstm_exp  = '{8'd0, 8'd3, 8'd9};
    flush_exp = '{8'd9, 8'd6, 8'd0};
    imp_exp   = '{8'd0, 8'd1, 8'd2, 8'd0};
    wrap_exp  = '{8'd0, 8'd63, 8'd189, 8'd122, 8'd118, 8'd177, 8'd43, 8'd228, 8'd220, 8'd220};

    rst_s = 1'b1;
    rst_w = 1'b1;
    x_s   = 2'd3;
    x_w   = 6'd63;
    hi_c  = 4'd0;

    // Reset held for two edges with nonzero data on the input pins.
    tick();
    tick();
    chk_ac("reset", 8'd0);
    chk("reset_b", if_b.io_out, 8'd0);

    // Step response with x_in = 3.
    rst_s = 1'b0;
    x_s   = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ac($sformatf("step%0d", i), step_exp[i]);
    end

    // Reset mid-stream while x_in stays at 3.
    rst_s = 1'b1;
    tick();
    chk_ac("midrst", 8'd0);
    rst_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ac($sformatf("postrst%0d", i), rstm_exp[i]);
    end

    // Drain the line with zeros, then a single-cycle impulse reads out h.
    x_s = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ac($sformatf("flush%0d", i), flush_exp[i]);
    end
    x_s = 2'd1;
    tick();
    chk_ac("imp0", imp_exp[0]);
    x_s = 2'd0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_ac($sformatf("imp%0d", i), imp_exp[i]);
    end

    // 8-tap configuration with x_in = 63: products and sum wrap mod 256.
    rst_w = 1'b1;
    tick();
    chk("wrap_rst", if_b.io_out, 8'd0);
    rst_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("wrap%0d", i), if_b.io_out, wrap_exp[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
